// File: rtl/microwave_pkg.sv
// Shared types and 7-segment constants for the microwave controller.
package microwave_pkg;
  typedef enum logic [2:0] {IDLE, SET, PWR, COOK, PAUSE, DONE} state_t;
  typedef logic [3:0] bcd_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
endpackage

// File: rtl/microwave_ctrl_pwr_if.sv
// Keypad/button/door inputs and display/magnetron outputs of the oven controller.
interface microwave_ctrl_pwr_if #(parameter int MIN_DIGITS = 2);
  logic [9:0]              keypad;
  logic                    startn;
  logic                    stopn;
  logic                    pwrn;
  logic                    door_closed;
  logic [6:0]              secs_ones_segs;
  logic [6:0]              secs_tens_segs;
  logic [7*MIN_DIGITS-1:0] min_segs;
  logic                    mag_on;
  logic                    done;

  modport master (
    output keypad, startn, stopn, pwrn, door_closed,
    input  secs_ones_segs, secs_tens_segs, min_segs, mag_on, done
  );
  modport slave (
    input  keypad, startn, stopn, pwrn, door_closed,
    output secs_ones_segs, secs_tens_segs, min_segs, mag_on, done
  );
endinterface

// File: rtl/seg7_bcd.sv
// BCD digit to 7-segment decoder; non-decimal codes blank the digit.
module seg7_bcd
  import microwave_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] segs
);
  always_comb begin
    segs = SEG_BLANK;
    for (int i = 0; i < 10; i++)
      if (bcd == bcd_t'(i)) segs = SEG_DIGIT[i];
  end
endmodule

// File: rtl/microwave_ctrl_pwr.sv
// Microwave controller: keypad time entry, BCD countdown, door interlock,
// pause/resume and a power level that duty-cycles the magnetron per window.
module microwave_ctrl_pwr
  import microwave_pkg::*;
#(
  parameter int CLK_PER_SEC = 100,
  parameter int MIN_DIGITS  = 2,
  parameter int PWR_LEVELS  = 10
) (
  input logic                 clk,
  input logic                 clear,
  microwave_ctrl_pwr_if.slave io
);
  localparam int NDIG  = 2 + MIN_DIGITS;
  localparam int PW    = $clog2(PWR_LEVELS + 1);
  localparam int PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);
  localparam logic [PW-1:0]    PWR_MAX  = PW'(PWR_LEVELS);
  localparam logic [PW-1:0]    WIN_LAST = PW'(PWR_LEVELS - 1);

  state_t               state, state_nxt;
  bcd_t [NDIG-1:0]      tm, tm_nxt;          // [0]=secs ones, [1]=secs tens, [2+k]=min k
  logic [PW-1:0]        power, power_nxt, win, win_nxt;
  logic [PRE_W-1:0]     presc, presc_nxt;
  logic [9:0]           key_r, key_q;
  logic [2:0]           btn_r, btn_q;        // {pwrn, stopn, startn}
  logic                 key_ev, start_ev, stop_ev, pwr_ev, borrow, mag_r;
  bcd_t                 key_val;
  logic [NDIG-1:0][6:0] segs;

  assign {pwr_ev, stop_ev, start_ev} = btn_q & ~btn_r;
  assign key_ev = (key_r != '0) && ((key_r & (key_r - 10'd1)) == '0) && (key_q == '0);

  always_comb begin
    key_val = '0;
    for (int i = 0; i < 10; i++)
      if (key_r[i]) key_val = bcd_t'(i);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      tm    <= '0;
      power <= PWR_MAX;
      presc <= '0;
      win   <= '0;
      key_r <= '0;
      key_q <= '0;
      btn_r <= '1;
      btn_q <= '1;
    end else begin
      state <= state_nxt;
      tm    <= tm_nxt;
      power <= power_nxt;
      presc <= presc_nxt;
      win   <= win_nxt;
      key_r <= io.keypad;
      key_q <= key_r;
      btn_r <= {io.pwrn, io.stopn, io.startn};
      btn_q <= btn_r;
    end
  end

  always_comb begin
    state_nxt = state;
    tm_nxt    = tm;
    power_nxt = power;
    presc_nxt = presc;
    win_nxt   = win;
    borrow    = 1'b0;
    unique case (state)
      IDLE, SET: begin
        if (stop_ev) begin
          tm_nxt    = '0;
          state_nxt = IDLE;
        end else if (start_ev && state == SET && io.door_closed) begin
          state_nxt = COOK;
          presc_nxt = '0;
          win_nxt   = '0;
        end else if (pwr_ev) begin
          state_nxt = PWR;
        end else if (key_ev) begin
          tm_nxt    = {tm[NDIG-2:0], key_val};
          state_nxt = (tm_nxt == '0) ? IDLE : SET;
        end
      end
      PWR: begin
        if (key_ev) power_nxt = (key_val == '0) ? PWR_MAX : PW'(key_val);
        if (key_ev || stop_ev) state_nxt = (tm == '0) ? IDLE : SET;
      end
      COOK: begin
        if (stop_ev || !io.door_closed) begin
          state_nxt = PAUSE;
        end else if (presc == PRE_LAST) begin
          presc_nxt = '0;
          win_nxt   = (win == WIN_LAST) ? '0 : win + 1'b1;
          // Borrow chain: seconds tens wraps to 5, every other digit to 9
          borrow = 1'b1;
          for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
              if (tm[i] == 4'd0) begin
                tm_nxt[i] = (i == 1) ? 4'd5 : 4'd9;
              end else begin
                tm_nxt[i] = tm[i] - 4'd1;
                borrow    = 1'b0;
              end
            end
          end
          if (tm_nxt == '0) state_nxt = DONE;
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          tm_nxt    = '0;
          power_nxt = PWR_MAX;
          state_nxt = IDLE;
        end else if (start_ev && io.door_closed) begin
          state_nxt = COOK;
        end
      end
      DONE: begin
        if (key_ev || stop_ev || start_ev) begin
          power_nxt = PWR_MAX;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_seg
    seg7_bcd u_seg (.bcd(tm[g]), .segs(segs[g]));
  end

  assign io.secs_ones_segs = segs[0];
  assign io.secs_tens_segs = segs[1];
  assign io.min_segs       = segs[NDIG-1:2];

  // Door gates the relay combinationally so opening it cuts power immediately
  assign mag_r     = (state == COOK) && (win < power);
  assign io.mag_on = mag_r & io.door_closed;
  assign io.done   = (state == DONE);
endmodule

// File: tb/tb_microwave_ctrl_pwr.sv
// Bench for microwave_ctrl_pwr: decimal-time reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_microwave_ctrl_pwr;
  localparam int CPS = 4;
  localparam int MD  = 2;
  localparam int PL  = 10;
  localparam int M_IDLE = 0, M_SET = 1, M_PWR = 2, M_COOK = 3, M_PAUSE = 4, M_DONE = 5;
  localparam logic [6:0] SEG [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  microwave_ctrl_pwr_if #(.MIN_DIGITS(MD)) io ();
  microwave_ctrl_pwr #(.CLK_PER_SEC(CPS), .MIN_DIGITS(MD), .PWR_LEVELS(PL)) dut (
    .clk(clk), .clear(clear), .io(io)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Reference model: time held as the decimal number shown on the panel (MMSS).
  int mode, t, pw, pre, win;
  logic [9:0] kh1, kh2;
  logic [2:0] bh1, bh2;   // {pwr, stop, start} history
  logic kev, sev, xev, pev;
  int d;

  always @(posedge clk) begin
    if (clear) begin
      mode = M_IDLE; t = 0; pw = PL; pre = 0; win = 0;
      kh1 = '0; kh2 = '0; bh1 = '1; bh2 = '1;
    end else begin
      kev = (kh1 != 0) && ($countones(kh1) == 1) && (kh2 == 0);
      d = 0;
      for (int i = 0; i < 10; i++) if (kh1[i]) d = i;
      sev = bh2[0] && !bh1[0];
      xev = bh2[1] && !bh1[1];
      pev = bh2[2] && !bh1[2];
      case (mode)
        M_IDLE, M_SET: begin
          if (xev) begin t = 0; mode = M_IDLE; end
          else if (sev && mode == M_SET && io.door_closed) begin mode = M_COOK; pre = 0; win = 0; end
          else if (pev) mode = M_PWR;
          else if (kev) begin t = (t * 10 + d) % 10000; mode = (t != 0) ? M_SET : M_IDLE; end
        end
        M_PWR: begin
          if (kev) pw = (d == 0) ? PL : d;
          if (kev || xev) mode = (t != 0) ? M_SET : M_IDLE;
        end
        M_COOK: begin
          if (xev || !io.door_closed) mode = M_PAUSE;
          else if (pre == CPS - 1) begin
            pre = 0;
            win = (win + 1) % PL;
            t = (t % 100 != 0) ? t - 1 : t - 100 + 59;
            if (t == 0) mode = M_DONE;
          end else pre = pre + 1;
        end
        M_PAUSE: begin
          if (xev) begin t = 0; pw = PL; mode = M_IDLE; end
          else if (sev && io.door_closed) mode = M_COOK;
        end
        M_DONE: if (kev || xev || sev) begin pw = PL; mode = M_IDLE; end
        default: mode = M_IDLE;
      endcase
      kh2 = kh1; kh1 = io.keypad;
      bh2 = bh1; bh1 = {io.pwrn, io.stopn, io.startn};
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    logic [6:0]  e_one, e_ten;
    logic [13:0] e_min;
    logic        e_mag, e_done;
    @(negedge clk);
    if (chk_en) begin
      e_one  = SEG[t % 10];
      e_ten  = SEG[(t / 10) % 10];
      e_min  = {SEG[(t / 1000) % 10], SEG[(t / 100) % 10]};
      e_mag  = (mode == M_COOK) && (win < pw) && io.door_closed;
      e_done = (mode == M_DONE);
      n_tests++;
      if (io.secs_ones_segs !== e_one || io.secs_tens_segs !== e_ten || io.min_segs !== e_min ||
          io.mag_on !== e_mag || io.done !== e_done) begin
        n_fail++;
        $display("FAIL cycle_cmp @%0t got segs=%h/%h/%h mag=%b done=%b want segs=%h/%h/%h mag=%b done=%b",
                 $time, io.min_segs, io.secs_tens_segs, io.secs_ones_segs, io.mag_on, io.done,
                 e_min, e_ten, e_one, e_mag, e_done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic key(input int k);
    io.keypad = 10'(1 << k); step(); io.keypad = '0; steps(2);
  endtask

  task automatic press_stop();
    io.stopn = 1'b0; step(); io.stopn = 1'b1; steps(2);
  endtask

  task automatic press_pwr();
    io.pwrn = 1'b0; step(); io.pwrn = 1'b1; steps(2);
  endtask

  // Returns on the edge where the start action takes effect
  task automatic start_edge();
    io.startn = 1'b0; step(); io.startn = 1'b1; step();
  endtask

  initial begin
    int on;
    io.keypad = '0; io.startn = 1'b1; io.stopn = 1'b1; io.pwrn = 1'b1; io.door_closed = 1'b0;
    // 1: reset and entry 2,5,9
    clear = 1'b1; steps(2); clear = 1'b0; chk_en = 1;
    chk("rst_ones", io.secs_ones_segs, 7'b0111111);
    chk("rst_min",  io.min_segs, 14'b0111111_0111111);
    chk("rst_mag",  io.mag_on, 0);
    chk("rst_done", io.done, 0);
    key(2); key(5); key(9);
    chk("t1_ones", io.secs_ones_segs, 7'b1101111);
    chk("t1_tens", io.secs_tens_segs, 7'b1101101);
    chk("t1_min",  io.min_segs, {7'b0111111, 7'b1011011});
    chk("t1_mode", mode, M_SET);
    // 2: door open blocks start; then cook and borrow across minutes
    start_edge(); step();
    chk("t2_open_hold", io.secs_ones_segs, 7'b1101111);
    chk("t2_open_mode", mode, M_SET);
    io.door_closed = 1'b1; step();
    io.startn = 1'b0; step();
    chk("t2_mag_1clk", io.mag_on, 0);
    io.startn = 1'b1; step();
    chk("t2_mag_2clk", io.mag_on, 1);
    steps(3);
    chk("t2_259_hold", io.secs_ones_segs, 7'b1101111);
    step();
    chk("t2_258", io.secs_ones_segs, 7'b1111111);
    for (int i = 0; i < 400 && t != 200; i++) step();
    chk("t2_reach_200", t, 200);
    steps(4);
    chk("t2_159_ones", io.secs_ones_segs, 7'b1101111);
    chk("t2_159_tens", io.secs_tens_segs, 7'b1101101);
    chk("t2_159_min",  io.min_segs, {7'b0111111, 7'b0000110});
    press_stop(); press_stop();
    chk("t2_cleared", io.secs_tens_segs, 7'b0111111);
    // 3: power 3, 0:03 -> done; then 0:20 window shape
    press_pwr(); key(3); key(3);
    chk("t3_pw", pw, 3);
    start_edge();
    chk("t3_mag_on", io.mag_on, 1);
    steps(11);
    chk("t3_not_done", io.done, 0);
    chk("t3_mag_late", io.mag_on, 1);
    step();
    chk("t3_done", io.done, 1);
    chk("t3_done_mag", io.mag_on, 0);
    chk("t3_done_ones", io.secs_ones_segs, 7'b0111111);
    press_stop();
    chk("t3_pw_reset", pw, PL);
    chk("t3_done_clr", io.done, 0);
    press_pwr(); key(3); key(2); key(0);
    chk("t3_020", io.secs_tens_segs, 7'b1011011);
    start_edge();
    on = 0;
    for (int i = 0; i < 40; i++) begin on += int'(io.mag_on); step(); end
    chk("t3_win_on", on, 12);
    chk("t3_win_wrap", io.mag_on, 1);
    for (int i = 0; i < 200 && io.done !== 1'b1; i++) step();
    chk("t3_done2", io.done, 1);
    press_stop();
    // 4: door open pauses, prescaler kept on resume
    key(4); key(5); start_edge(); steps(2);
    io.door_closed = 1'b0; #1;
    chk("t4_interlock", io.mag_on, 0);
    steps(10);
    chk("t4_frozen", io.secs_ones_segs, 7'b1101101);
    chk("t4_pause", mode, M_PAUSE);
    io.door_closed = 1'b1; steps(3);
    chk("t4_stay_pause", mode, M_PAUSE);
    start_edge(); step();
    chk("t4_resume_45", io.secs_ones_segs, 7'b1101101);
    step();
    chk("t4_resume_44", io.secs_ones_segs, 7'b1100110);
    press_stop(); press_stop();
    chk("t4_idle", mode, M_IDLE);
    chk("t4_zero", io.secs_ones_segs, 7'b0111111);
    // 5: overflow discard, non-one-hot ignored, start+stop together
    key(1); key(2); key(3); key(4); key(5);
    chk("t5_min", io.min_segs, {7'b1011011, 7'b1001111});
    chk("t5_tens", io.secs_tens_segs, 7'b1100110);
    io.keypad = 10'b0000010001; step(); io.keypad = '0; steps(2);
    chk("t5_bad_key", io.secs_ones_segs, 7'b1101101);
    io.startn = 1'b0; io.stopn = 1'b0; step(); io.startn = 1'b1; io.stopn = 1'b1; steps(2);
    chk("t5_both_min", io.min_segs, 14'b0111111_0111111);
    chk("t5_both_mode", mode, M_IDLE);
    // tens borrow: 1:90 -> 1:89
    key(1); key(9); key(0); start_edge(); steps(4);
    chk("t5_189_tens", io.secs_tens_segs, 7'b1111111);
    chk("t5_189_ones", io.secs_ones_segs, 7'b1101111);
    press_stop(); press_stop();
    // 6: clear mid-cook restores full power
    press_pwr(); key(2); key(1); key(0); start_edge(); steps(5);
    clear = 1'b1; step();
    chk("t6_ones", io.secs_ones_segs, 7'b0111111);
    chk("t6_tens", io.secs_tens_segs, 7'b0111111);
    chk("t6_mag", io.mag_on, 0);
    chk("t6_done", io.done, 0);
    clear = 1'b0;
    chk("t6_pw", pw, PL);
    key(5); start_edge();
    on = 0;
    for (int i = 0; i < 12; i++) begin on += int'(io.mag_on); step(); end
    chk("t6_full_pwr", on, 12);
    for (int i = 0; i < 100 && io.done !== 1'b1; i++) step();
    chk("t6_done2", io.done, 1);
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
